// File: rtl/text_scanner.sv
// Character-cell text scanner: raster counters, a 2-stage display pipeline and a 4-bit text buffer.
// Optional blinking cursor at the last written cell when TEXT_SCANNER_CURSOR_EN is defined.
module text_scanner #(
    parameter int COLS    = 20,
    parameter int ROWS    = 10,
    parameter int H_BLANK = 32,
    parameter int V_BLANK = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_req,
    input  logic [7:0] wr_addr,
    input  logic [3:0] wr_char,
    output logic       wr_ack,
    output logic       wr_err,
    output logic       en,
    output logic [3:0] character,
    output logic [2:0] dot_count,
    output logic [3:0] scan_count,
    output logic       hsync,
    output logic       vsync
);

    localparam int H_ACT = COLS * 8;
    localparam int H_TOT = H_ACT + H_BLANK;
    localparam int V_ACT = ROWS * 16;
    localparam int V_TOT = V_ACT + V_BLANK;
    localparam int CELLS = COLS * ROWS;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int AW    = (CELLS > 1) ? $clog2(CELLS) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACT);
    localparam logic [HW-1:0] H_SYNC_C = HW'(H_ACT + H_BLANK / 2);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACT);
    localparam logic [VW-1:0] V_SYNC_C = VW'(V_ACT + V_BLANK / 2);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          h_wrap, v_wrap;

    // Stage p0: raster counters
    always_comb begin
        h_wrap = (h_q == H_LAST);
        v_wrap = (v_q == V_LAST);
        h_d    = h_q + HW'(1);
        v_d    = v_q;
        if (h_wrap) begin
            h_d = '0;
            v_d = v_wrap ? '0 : v_q + VW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    logic          act_p0;
    logic [AW-1:0] addr_p0;

    always_comb begin
        act_p0  = (h_q < H_ACT_C) && (v_q < V_ACT_C);
        addr_p0 = '0;
        if (act_p0) begin
            addr_p0 = AW'(32'(v_q[VW-1:4]) * 32'(COLS) + 32'(h_q[HW-1:3]));
        end
    end

    logic       wr_in_range;
    logic       wr_ok;
    logic [3:0] mem [CELLS];
    logic       wr_ack_q, wr_err_q;

    assign wr_in_range = 32'(wr_addr) < 32'(CELLS);
    assign wr_ok       = rst_n && wr_req && wr_in_range;

    // Buffer is never cleared; a write and a read of the same cell on one edge returns the old value.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr[AW-1:0]] <= wr_char;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ack_q <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            wr_ack_q <= wr_req && wr_in_range;
            wr_err_q <= wr_req && !wr_in_range;
        end
    end

`ifdef TEXT_SCANNER_CURSOR_EN
    logic [AW-1:0] cursor_q;
    logic [4:0]    frame_q;
    logic          cur_p0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cursor_q <= '0;
            frame_q  <= '0;
        end else begin
            if (wr_ok) begin
                cursor_q <= wr_addr[AW-1:0];
            end
            if (h_wrap && v_wrap) begin
                frame_q <= frame_q + 5'd1;
            end
        end
    end

    assign cur_p0 = act_p0 && frame_q[4] && (addr_p0 == cursor_q);
`endif

    logic          act_p1_q;
    logic [AW-1:0] addr_p1_q;
    logic [2:0]    dot_p1_q;
    logic [3:0]    scan_p1_q;
    logic          hs_p1_q, vs_p1_q;
`ifdef TEXT_SCANNER_CURSOR_EN
    logic          cur_p1_q;
`endif

    // Stage p1: cell address and position attributes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_p1_q  <= 1'b0;
            addr_p1_q <= '0;
            dot_p1_q  <= '0;
            scan_p1_q <= '0;
            hs_p1_q   <= 1'b0;
            vs_p1_q   <= 1'b0;
`ifdef TEXT_SCANNER_CURSOR_EN
            cur_p1_q  <= 1'b0;
`endif
        end else begin
            act_p1_q  <= act_p0;
            addr_p1_q <= addr_p0;
            dot_p1_q  <= h_q[2:0];
            scan_p1_q <= v_q[3:0];
            hs_p1_q   <= (h_q >= H_SYNC_C);
            vs_p1_q   <= (v_q >= V_SYNC_C);
`ifdef TEXT_SCANNER_CURSOR_EN
            cur_p1_q  <= cur_p0;
`endif
        end
    end

    logic [3:0] rd_char;

    always_comb begin
        rd_char = mem[addr_p1_q];
`ifdef TEXT_SCANNER_CURSOR_EN
        if (cur_p1_q) begin
            rd_char = 4'hF;
        end
`endif
    end

    logic       en_p2_q, hs_p2_q, vs_p2_q;
    logic [3:0] char_p2_q, scan_p2_q;
    logic [2:0] dot_p2_q;

    // Stage p2: buffer read and registered display outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_p2_q   <= 1'b0;
            char_p2_q <= '0;
            dot_p2_q  <= '0;
            scan_p2_q <= '0;
            hs_p2_q   <= 1'b0;
            vs_p2_q   <= 1'b0;
        end else begin
            en_p2_q   <= act_p1_q;
            char_p2_q <= act_p1_q ? rd_char : 4'h0;
            dot_p2_q  <= act_p1_q ? dot_p1_q : 3'h0;
            scan_p2_q <= act_p1_q ? scan_p1_q : 4'h0;
            hs_p2_q   <= hs_p1_q;
            vs_p2_q   <= vs_p1_q;
        end
    end

    assign wr_ack     = wr_ack_q;
    assign wr_err     = wr_err_q;
    assign en         = en_p2_q;
    assign character  = char_p2_q;
    assign dot_count  = dot_p2_q;
    assign scan_count = scan_p2_q;
    assign hsync      = hs_p2_q;
    assign vsync      = vs_p2_q;

endmodule

// File: tb/tb_text_scanner.sv
// Bench for text_scanner: a raster/buffer model queues the expected outputs two cycles ahead
// of the DUT, plus directed checks of writes, read-before-write, sync widths and reset.
module tb_text_scanner;

    localparam int COLS  = 20;
    localparam int ROWS  = 10;
    localparam int HB    = 32;
    localparam int VB    = 8;
    localparam int HT    = COLS * 8 + HB;
    localparam int VT    = ROWS * 16 + VB;
    localparam int CELLS = COLS * ROWS;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_req;
    logic [7:0] wr_addr;
    logic [3:0] wr_char;
    logic       wr_ack, wr_err, en, hsync, vsync;
    logic [3:0] character, scan_count;
    logic [2:0] dot_count;

    always #5 clk = ~clk;

    text_scanner #(.COLS(COLS), .ROWS(ROWS), .H_BLANK(HB), .V_BLANK(VB)) dut (
        .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .wr_addr(wr_addr), .wr_char(wr_char),
        .wr_ack(wr_ack), .wr_err(wr_err), .en(en), .character(character),
        .dot_count(dot_count), .scan_count(scan_count), .hsync(hsync), .vsync(vsync)
    );

    int          errors = 0;
    int          checks = 0;
    int          mh = 0;
    int          mv = 0;
    bit          armed = 1'b0;
    logic [1:0]  exp_wr = 2'b00;
    logic [3:0]  mbuf [CELLS];
    logic [13:0] expq [$];

    function automatic logic [3:0] pat(int i);
        return 4'((i * 7 + 3) % 16);
    endfunction

    function automatic logic [13:0] model_out(int h, int v);
        logic       a;
        logic [3:0] c, s;
        logic [2:0] d;
        a = (h < COLS * 8) && (v < ROWS * 16);
        c = 4'h0;
        d = 3'h0;
        s = 4'h0;
        if (a) begin
            c = mbuf[(v / 16) * COLS + h / 8];
            d = 3'(h % 8);
            s = 4'(v % 16);
        end
        return {a, c, d, s, (h >= COLS * 8 + HB / 2), (v >= ROWS * 16 + VB / 2)};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h (h=%0d v=%0d)", tag, obs, exp, mh, mv);
        end
    endtask

    // Called at a falling edge with this cycle's inputs already driven.
    task automatic tick();
        logic [13:0] obs, e;
        obs = {en, character, dot_count, scan_count, hsync, vsync};
        if (expq.size() == 2) begin
            e = expq.pop_front();
            chk("scan_out", 16'(obs), 16'(e));
        end
        if (armed) chk("wr_resp", 16'({wr_ack, wr_err}), 16'(exp_wr));
        if (!rst_n) begin
            expq.delete();
            expq.push_back('0);
            expq.push_back('0);
            exp_wr = 2'b00;
            mh = 0;
            mv = 0;
            armed = 1'b1;
        end else begin
            exp_wr = 2'b00;
            if (wr_req) begin
                if (int'(wr_addr) < CELLS) begin
                    mbuf[wr_addr] = wr_char;
                    exp_wr = 2'b10;
                end else begin
                    exp_wr = 2'b01;
                end
            end
            expq.push_back(model_out(mh, mv));
            mh++;
            if (mh == HT) begin
                mh = 0;
                mv++;
                if (mv == VT) mv = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic run_to(input int h, input int v);
        int n;
        n = 0;
        while (!(mh == h && mv == v) && n < 40000) begin
            tick();
            n++;
        end
        checks++;
        assert (mh == h && mv == v) else begin
            errors++;
            $error("FAIL run_to: reached h=%0d v=%0d, wanted h=%0d v=%0d", mh, mv, h, v);
        end
    endtask

    initial begin
        int         ce, ch, cv;
        logic [3:0] keep;

        rst_n   = 1'b0;
        wr_req  = 1'b1;
        wr_addr = 8'd5;
        wr_char = 4'hA;
        tick();
        tick();
        rst_n  = 1'b1;
        wr_req = 1'b0;
        chk("reset_state", 16'({en, character, dot_count, scan_count, hsync, vsync, wr_ack, wr_err}), 16'h0);

        for (int i = 0; i < CELLS; i++) begin
            wr_req  = 1'b1;
            wr_addr = 8'(i);
            wr_char = pat(i);
            if (i == 2) chk("first_en", 16'({en, dot_count, scan_count}), 16'({1'b1, 3'd0, 4'd0}));
            tick();
        end
        wr_req = 1'b0;

        wr_req  = 1'b1;
        wr_addr = 8'd200;
        wr_char = 4'hF;
        tick();
        wr_req = 1'b0;
        chk("oor_200_err", 16'({wr_ack, wr_err}), 16'(2'b01));
        tick();
        chk("oor_200_pulse", 16'({wr_ack, wr_err}), 16'(2'b00));
        wr_req  = 1'b1;
        wr_addr = 8'd255;
        tick();
        wr_req = 1'b0;
        tick();

        wr_req  = 1'b1;
        wr_addr = 8'd21;
        wr_char = 4'h7;
        tick();
        wr_req = 1'b0;
        chk("ack_21", 16'({wr_ack, wr_err}), 16'(2'b10));
        tick();
        chk("ack_21_pulse", 16'({wr_ack, wr_err}), 16'(2'b00));

        run_to(10, 17);
        for (int k = 0; k < 8; k++) begin
            chk("line17_cell21", 16'({en, character, dot_count}), 16'({1'b1, 4'h7, 3'(k)}));
            tick();
        end

        run_to(9, 33);
        keep    = mbuf[41];
        wr_req  = 1'b1;
        wr_addr = 8'd41;
        wr_char = 4'hC;
        tick();
        wr_req = 1'b0;
        chk("rbw_old", 16'(character), 16'(keep));
        tick();
        chk("rbw_new", 16'(character), 16'(4'hC));

        for (int k = 0; k < 300; k++) begin
            wr_req  = 1'($urandom_range(0, 1));
            wr_addr = 8'($urandom_range(0, 255));
            wr_char = 4'($urandom_range(0, 15));
            tick();
        end
        wr_req = 1'b0;

        ce = 0;
        ch = 0;
        cv = 0;
        repeat (HT * VT) begin
            ce += int'(en);
            ch += int'(hsync);
            cv += int'(vsync);
            tick();
        end
        chk("frame_en_cycles", 16'(ce), 16'(25600));
        chk("frame_hsync_cycles", 16'(ch), 16'(2688));
        chk("frame_vsync_cycles", 16'(cv), 16'(768));

        run_to(100, 50);
        keep    = mbuf[0];
        rst_n   = 1'b0;
        wr_req  = 1'b1;
        wr_addr = 8'd0;
        wr_char = ~keep;
        tick();
        rst_n  = 1'b1;
        wr_req = 1'b0;
        chk("midreset_outputs", 16'({en, character, dot_count, scan_count, hsync, vsync, wr_ack, wr_err}), 16'h0);
        tick();
        chk("midreset_pipe", 16'({en, character, dot_count, scan_count, hsync, vsync}), 16'h0);
        tick();
        chk("midreset_restart", 16'({en, character, dot_count, scan_count}), 16'({1'b1, keep, 3'd0, 4'd0}));

        ce = 0;
        ch = 0;
        repeat (HT) begin
            ce += int'(en);
            ch += int'(hsync);
            tick();
        end
        chk("line_en_cycles", 16'(ce), 16'(160));
        chk("line_hsync_cycles", 16'(ch), 16'(16));
        repeat (2 * HT) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
